bpsk_symbol_sequencer: RTL

//  Frames a byte stream into BPSK symbols for the carrier wave generator. It accepts

---
 rtl/bpsk_symbol_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bpsk_symbol_sequencer.sv
// rtl/bpsk_symbol_sequencer.sv - frames a byte stream into BPSK symbols
// Preamble, payload MSB first, guard tail; each symbol is held for one carrier period.
module bpsk_symbol_sequencer #(
  parameter int         SPS       = 52,
  parameter logic [7:0] PRE_PAT   = 8'hAA,
  parameter int         GUARD_SYM = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       gen_reset,
  output logic       gen_data,
  output logic       sym_strobe,
  output logic       busy,
  output logic       underrun
);

  localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int GW = (GUARD_SYM > 1) ? $clog2(GUARD_SYM) : 1;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, GUARD} state_t;

  state_t        state;
  logic [6:0]    shift;      // bits still to send after the one on gen_data
  logic          cur_last;
  logic [7:0]    hold_byte;
  logic          hold_last;
  logic          hold_full;
  logic [CW-1:0] samp_cnt;
  logic [2:0]    bit_cnt;
  logic [GW-1:0] guard_cnt;

  logic take, start, sym_end, byte_end, load;

  assign in_ready = !reset && !hold_full && (state != GUARD);
  assign take     = in_valid && in_ready;
  assign start    = take || hold_full;
  assign sym_end  = (samp_cnt == CW'(SPS - 1));
  assign byte_end = sym_end && (bit_cnt == 3'd7);
  assign load     = byte_end && ((state == PREAMBLE) ||
                                 ((state == DATA) && !cur_last && hold_full));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shift      <= '0;
      cur_last   <= 1'b0;
      hold_byte  <= '0;
      hold_last  <= 1'b0;
      hold_full  <= 1'b0;
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      guard_cnt  <= '0;
      gen_reset  <= 1'b1;
      gen_data   <= 1'b1;
      sym_strobe <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;

      // A write on the unload edge wins, so the buffer stays full with the new byte.
      if (take) begin
        hold_byte <= in_data;
        hold_last <= in_last;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          sym_strobe <= start;
          samp_cnt   <= '0;
          bit_cnt    <= '0;
          if (start) begin
            state     <= PREAMBLE;
            shift     <= PRE_PAT[6:0];
            gen_data  <= PRE_PAT[7];
            gen_reset <= 1'b0;
            busy      <= 1'b1;
          end
        end

        PREAMBLE, DATA: begin
          sym_strobe <= sym_end;
          samp_cnt   <= sym_end ? '0 : samp_cnt + CW'(1);
          if (sym_end) begin
            if (byte_end) begin
              bit_cnt <= '0;
              if (load) begin
                state    <= DATA;
                shift    <= hold_byte[6:0];
                gen_data <= hold_byte[7];
                cur_last <= hold_last;
              end else begin
                state     <= GUARD;
                gen_data  <= 1'b1;
                guard_cnt <= '0;
                underrun  <= !cur_last;
              end
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              gen_data <= shift[6];
              shift    <= {shift[5:0], 1'b0};
            end
          end
        end

        GUARD: begin
          samp_cnt <= sym_end ? '0 : samp_cnt + CW'(1);
          if (sym_end && (guard_cnt == GW'(GUARD_SYM - 1))) begin
            state      <= IDLE;
            guard_cnt  <= '0;
            gen_reset  <= 1'b1;
            busy       <= 1'b0;
            sym_strobe <= 1'b0;
          end else begin
            sym_strobe <= sym_end;
            if (sym_end) guard_cnt <= guard_cnt + GW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
